control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Hardwired Moore control sequencer driving the datapath's bus-drive, register-load, memory and ALU-select strobes.
//  Replaces the hand-written stimulus sequencing used for datapath bring-up.
//  Fetches from PC, decodes IR[31:27], steps T0..T7 per instruction class, then returns to fetch.
// PARAMETERS
//  IR_W      32  instruction register width
//  OPC_W     5   opcode field width, IR[31:27]
//  MEM_WAIT  0   extra cycles Read is held in memory-read states (0..3)
// PORTS
//  Clock    in   1      system clock, rising-edge
//  Clear    in   1      reset, asynchronous, active-low
//  IR       in   IR_W   instruction register contents from datapath
//  Stop     in   1      halt request, sampled only at instruction boundary (end of the last step)
//  drv      out  9      bus drivers {PCout,Zhighout,Zlowout,MDRout,HIout,LOout,Cout,BAout,Rout}
//  ld       out  9      register loads {PCin,IRin,MARin,MDRin,Yin,Zin,HIin,LOin,Rin}
//  gr       out  3      select-and-encode {Gra,Grb,Grc}
//  IncPC    out  1      ALU computes PC+1
//  Read     out  1      MDR source = Mdatain; memory read
//  Write    out  1      memory write
//  alu_op   out  OPC_W  ALU operation code
//  Run      out  1      1 while executing; 0 in RESET/HALTED
//  Illegal  out  1      1-cycle pulse on unsupported opcode
// BEHAVIOUR
//  Reset: Clear=0 asynchronously forces RESET; all outputs 0, including mid-instruction.
//   First edge after release: RESET->T0, Run=1.
//  Outputs decode from state register only (Moore); alu_op registered from IR at the end of T2.
//  Fetch (all instr):
//   T0  PCout MARin IncPC Zin
//   T1  Zlowout PCin Read MDRin; held MEM_WAIT extra cycles via wait counter
//   T2  MDRout IRin
//  Per class, from T3:
//   R-type add/sub/and/or/shr/shra/shl/ror/rol (00011..01011)
//      T3 Grb Rout Yin; T4 Grc Rout Zin; T5 Zlowout Gra Rin
//   immediate addi/andi/ori (01100..01110), alu_op mapped to add/and/or
//      T3 Grb Rout Yin; T4 Cout Zin; T5 Zlowout Gra Rin
//   neg/not (10001/10010)
//      T3 Grb Rout Zin; T4 Zlowout Gra Rin
//   mul/div (01111/10000)
//      T3 Gra Rout Yin; T4 Grb Rout Zin; T5 Zlowout LOin; T6 Zhighout HIin
//   ld (00000)
//      T3 Grb BAout Yin; T4 Cout Zin(add); T5 Zlowout MARin; T6 Read MDRin (+MEM_WAIT); T7 MDRout Gra Rin
//   ldi (00001)
//      T3 Grb BAout Yin; T4 Cout Zin(add); T5 Zlowout Gra Rin
//   st (00010)
//      T3-T5 as ld; T6 Gra Rout MDRin (Read=0); T7 Write
//   mfhi/mflo (11000/11001)
//      T3 HIout|LOout Gra Rin
//   nop (11010)
//      return to T0 after T2
//   halt (11011)
//      ->HALTED: Run=0, all strobes 0; exit only via Clear
//   other opcodes: Illegal=1 in T3, then treated as nop
//  Instruction boundary: Stop=1 at the end of the last step -> HALTED, otherwise -> T0.
//   Stop arriving mid-instruction is ignored unless still high at the boundary.
//  Wait counter: 2 bits, loaded with MEM_WAIT on entry to a read state, state advances when it reaches 0.
//   MEM_WAIT=0 gives zero extra cycles.
//  Latency (MEM_WAIT=0): nop 3 cycles, neg/not 5, R/imm/ldi/mfhi 6/6/6/4, mul/div 7, ld/st 8.
// CONFIGURATION
//  CU_MULDIV_EN defined: mul/div sequence as above.
//  CU_MULDIV_EN undefined: mul/div decode as illegal (Illegal pulse, nop); HIin and LOin tied 0.
// STRUCTURE
//  cpu_defs_pkg: opcode localparams, ALU op codes, state enum (RESET,T0..T7,HALTED), drv/ld bit indices.
//  Sub-module cu_decode: combinational IR[31:27] -> instruction class + mapped alu_op.
// TESTING
//  Clear=0 pulse mid-T4 of add -> all outputs 0 same cycle; after release T0 with PCout=MARin=IncPC=Zin=1.
//  IR=32'h28918000 (and) -> T3 Grb Rout Yin; T4 Grc Rout Zin alu_op=00101; T5 Zlowout Gra Rin; T0 next.
//  IR opcode 10001 (neg) -> T3 Grb Rout Zin alu_op=10001; T4 Zlowout Gra Rin; 5 cycles total.
//  ld with MEM_WAIT=2 -> Read held 3 cycles in T1 and in T6; total 12 cycles.
//  st -> T6 MDRin=1 with Read=0; T7 Write=1 for exactly 1 cycle.
//  halt, or Stop=1 at the last step of mul -> HALTED, Run=0; opcode 10111 -> Illegal 1-cycle pulse.
//  Build with CU_MULDIV_EN undefined -> mul -> Illegal pulse, HIin/LOin never asserted.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs_pkg
// Shared definitions for the hardwired control sequencer:
//   - opcode values carried in IR[31:27]
//   - ALU operation codes driven on alu_op
//   - sequencer state encodings (RESET, T0..T7, HALTED)
//   - bit positions inside the drv / ld / gr strobe vectors
//   - instruction class enumeration produced by cu_decode
// ---------------------------------------------------------------------------
package cpu_defs_pkg;

    // Opcodes
    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ROL  = 5'b01011;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_ANDI = 5'b01101;
    localparam logic [4:0] OPC_ORI  = 5'b01110;
    localparam logic [4:0] OPC_MUL  = 5'b01111;
    localparam logic [4:0] OPC_DIV  = 5'b10000;
    localparam logic [4:0] OPC_NEG  = 5'b10001;
    localparam logic [4:0] OPC_NOT  = 5'b10010;
    localparam logic [4:0] OPC_MFHI = 5'b11000;
    localparam logic [4:0] OPC_MFLO = 5'b11001;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    // ALU operation codes share the R-type opcode numbering
    localparam logic [4:0] ALU_ADD  = OPC_ADD;
    localparam logic [4:0] ALU_AND  = OPC_AND;
    localparam logic [4:0] ALU_OR   = OPC_OR;
    localparam logic [4:0] ALU_NONE = 5'b00000;

    // Sequencer states
    localparam logic [3:0] ST_RESET  = 4'd0;
    localparam logic [3:0] ST_T0     = 4'd1;
    localparam logic [3:0] ST_T1     = 4'd2;
    localparam logic [3:0] ST_T2     = 4'd3;
    localparam logic [3:0] ST_T3     = 4'd4;
    localparam logic [3:0] ST_T4     = 4'd5;
    localparam logic [3:0] ST_T5     = 4'd6;
    localparam logic [3:0] ST_T6     = 4'd7;
    localparam logic [3:0] ST_T7     = 4'd8;
    localparam logic [3:0] ST_HALTED = 4'd9;

    // drv = {PCout,Zhighout,Zlowout,MDRout,HIout,LOout,Cout,BAout,Rout}
    localparam int DRV_PCOUT  = 8;
    localparam int DRV_ZHOUT  = 7;
    localparam int DRV_ZLOUT  = 6;
    localparam int DRV_MDROUT = 5;
    localparam int DRV_HIOUT  = 4;
    localparam int DRV_LOOUT  = 3;
    localparam int DRV_COUT   = 2;
    localparam int DRV_BAOUT  = 1;
    localparam int DRV_ROUT   = 0;

    // ld = {PCin,IRin,MARin,MDRin,Yin,Zin,HIin,LOin,Rin}
    localparam int LD_PCIN  = 8;
    localparam int LD_IRIN  = 7;
    localparam int LD_MARIN = 6;
    localparam int LD_MDRIN = 5;
    localparam int LD_YIN   = 4;
    localparam int LD_ZIN   = 3;
    localparam int LD_HIIN  = 2;
    localparam int LD_LOIN  = 1;
    localparam int LD_RIN   = 0;

    // gr = {Gra,Grb,Grc}
    localparam int GR_A = 2;
    localparam int GR_B = 1;
    localparam int GR_C = 0;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_RTYPE,
        CLS_IMM,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_LD,
        CLS_LDI,
        CLS_ST,
        CLS_MFHI,
        CLS_MFLO,
        CLS_HALT,
        CLS_ILLEGAL
    } cls_t;

    function automatic logic in_range(input logic [4:0] v,
                                      input logic [4:0] lo,
                                      input logic [4:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/cu_decode.sv
// ---------------------------------------------------------------------------
// cu_decode
// Combinational opcode decoder: maps IR[31:27] to an instruction class and
// the ALU operation the sequence will use.
// Build option: CU_MULDIV_EN -- when undefined, mul/div decode as illegal.
// Ports:
//   i_opcode  in   OPC_W  opcode field
//   o_cls     out  cls_t  instruction class
//   o_alu_op  out  OPC_W  ALU operation code
// ---------------------------------------------------------------------------
module cu_decode
    import cpu_defs_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] i_opcode,
    output cls_t             o_cls,
    output logic [OPC_W-1:0] o_alu_op
);

    logic [4:0] w_opc;
    logic [4:0] w_alu;

    assign w_opc    = 5'(i_opcode);
    assign o_alu_op = OPC_W'(w_alu);

    always_comb begin
        o_cls = CLS_ILLEGAL;
        w_alu = ALU_NONE;
        if (in_range(w_opc, OPC_ADD, OPC_ROL)) begin
            o_cls = CLS_RTYPE;
            w_alu = w_opc;
        end else begin
            case (w_opc)
                OPC_ADDI: begin o_cls = CLS_IMM; w_alu = ALU_ADD; end
                OPC_ANDI: begin o_cls = CLS_IMM; w_alu = ALU_AND; end
                OPC_ORI:  begin o_cls = CLS_IMM; w_alu = ALU_OR;  end
                OPC_NEG,
                OPC_NOT:  begin o_cls = CLS_UNARY; w_alu = w_opc; end
`ifdef CU_MULDIV_EN
                OPC_MUL,
                OPC_DIV:  begin o_cls = CLS_MULDIV; w_alu = w_opc; end
`else
                OPC_MUL,
                OPC_DIV:  o_cls = CLS_ILLEGAL;
`endif
                // Effective-address computation is an add of base and constant
                OPC_LD:   begin o_cls = CLS_LD;  w_alu = ALU_ADD; end
                OPC_LDI:  begin o_cls = CLS_LDI; w_alu = ALU_ADD; end
                OPC_ST:   begin o_cls = CLS_ST;  w_alu = ALU_ADD; end
                OPC_MFHI: o_cls = CLS_MFHI;
                OPC_MFLO: o_cls = CLS_MFLO;
                OPC_NOP:  o_cls = CLS_NOP;
                OPC_HALT: o_cls = CLS_HALT;
                default:  o_cls = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Hardwired Moore control sequencer for the datapath. Fetches (T0..T2),
// decodes IR[31:27], steps T3..T7 per instruction class and returns to T0,
// or to HALTED on halt / Stop at an instruction boundary.
// Build option: CU_MULDIV_EN -- enables the mul/div sequence; when undefined
// mul/div are illegal and HIin/LOin are tied low.
// Ports:
//   Clock    in   1      rising-edge clock
//   Clear    in   1      asynchronous active-low reset
//   IR       in   IR_W   instruction register contents
//   Stop     in   1      halt request, honoured only at instruction boundary
//   drv      out  9      bus drivers {PCout,Zhighout,Zlowout,MDRout,HIout,LOout,Cout,BAout,Rout}
//   ld       out  9      register loads {PCin,IRin,MARin,MDRin,Yin,Zin,HIin,LOin,Rin}
//   gr       out  3      {Gra,Grb,Grc}
//   IncPC    out  1      ALU computes PC+1
//   Read     out  1      memory read / MDR from Mdatain
//   Write    out  1      memory write
//   alu_op   out  OPC_W  ALU operation, captured at the end of T2
//   Run      out  1      executing (0 in RESET/HALTED)
//   Illegal  out  1      one-cycle pulse on unsupported opcode
// ---------------------------------------------------------------------------
module control_unit
    import cpu_defs_pkg::*;
#(
    parameter int IR_W     = 32,
    parameter int OPC_W    = 5,
    parameter int MEM_WAIT = 0
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic [IR_W-1:0]  IR,
    input  logic             Stop,
    output logic [8:0]       drv,
    output logic [8:0]       ld,
    output logic [2:0]       gr,
    output logic             IncPC,
    output logic             Read,
    output logic             Write,
    output logic [OPC_W-1:0] alu_op,
    output logic             Run,
    output logic             Illegal
);

    localparam logic [1:0] WAIT_INIT = 2'(MEM_WAIT);

    logic [3:0]       r_state;
    logic [1:0]       r_wait;
    cls_t             r_cls;
    logic [OPC_W-1:0] r_alu_op;

    logic [OPC_W-1:0] w_opcode;
    cls_t             w_dec_cls;
    logic [OPC_W-1:0] w_dec_alu;
    logic [3:0]       w_state_next;
    logic [1:0]       w_wait_next;
    logic             w_last_step;
    logic             w_unused_ir;

    assign w_opcode    = IR[IR_W-1 -: OPC_W];
    assign w_unused_ir = ^IR[IR_W-OPC_W-1:0];

    cu_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .i_opcode (w_opcode),
        .o_cls    (w_dec_cls),
        .o_alu_op (w_dec_alu)
    );

    // Next-state logic. T2 steers on the live decode because nop/halt leave
    // from T2; later steps use the class captured at the end of T2.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        w_last_step  = 1'b0;
        case (r_state)
            ST_RESET: w_state_next = ST_T0;
            ST_T0: begin
                w_state_next = ST_T1;
                w_wait_next  = WAIT_INIT;
            end
            ST_T1: begin
                if (r_wait == 2'd0) w_state_next = ST_T2;
                else                w_wait_next  = r_wait - 2'd1;
            end
            ST_T2: begin
                case (w_dec_cls)
                    CLS_NOP:  w_last_step  = 1'b1;
                    CLS_HALT: w_state_next = ST_HALTED;
                    default:  w_state_next = ST_T3;
                endcase
            end
            ST_T3: begin
                case (r_cls)
                    CLS_MFHI, CLS_MFLO, CLS_ILLEGAL: w_last_step  = 1'b1;
                    default:                         w_state_next = ST_T4;
                endcase
            end
            ST_T4: begin
                if (r_cls == CLS_UNARY) w_last_step  = 1'b1;
                else                    w_state_next = ST_T5;
            end
            ST_T5: begin
                case (r_cls)
                    CLS_LD: begin
                        w_state_next = ST_T6;
                        w_wait_next  = WAIT_INIT;
                    end
                    CLS_ST, CLS_MULDIV: w_state_next = ST_T6;
                    default:            w_last_step  = 1'b1;
                endcase
            end
            ST_T6: begin
                case (r_cls)
                    CLS_LD: begin
                        if (r_wait == 2'd0) w_state_next = ST_T7;
                        else                w_wait_next  = r_wait - 2'd1;
                    end
                    CLS_ST:  w_state_next = ST_T7;
                    default: w_last_step  = 1'b1;
                endcase
            end
            ST_T7:     w_last_step  = 1'b1;
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_RESET;
        endcase
        // Stop is only honoured at the instruction boundary
        if (w_last_step) begin
            w_state_next = Stop ? ST_HALTED : ST_T0;
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_state  <= ST_RESET;
            r_wait   <= 2'd0;
            r_cls    <= CLS_NOP;
            r_alu_op <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            if (r_state == ST_T2) begin
                r_cls    <= w_dec_cls;
                r_alu_op <= w_dec_alu;
            end
        end
    end

    assign Run    = (r_state != ST_RESET) && (r_state != ST_HALTED);
    assign alu_op = Run ? r_alu_op : '0;

    // Moore output decode: state register and captured class only
    always_comb begin
        drv     = '0;
        ld      = '0;
        gr      = '0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        Illegal = 1'b0;
        case (r_state)
            ST_T0: begin
                drv[DRV_PCOUT] = 1'b1;
                ld[LD_MARIN]   = 1'b1;
                ld[LD_ZIN]     = 1'b1;
                IncPC          = 1'b1;
            end
            ST_T1: begin
                drv[DRV_ZLOUT] = 1'b1;
                ld[LD_PCIN]    = 1'b1;
                ld[LD_MDRIN]   = 1'b1;
                Read           = 1'b1;
            end
            ST_T2: begin
                drv[DRV_MDROUT] = 1'b1;
                ld[LD_IRIN]     = 1'b1;
            end
            ST_T3: begin
                case (r_cls)
                    CLS_RTYPE, CLS_IMM: begin
                        gr[GR_B] = 1'b1; drv[DRV_ROUT] = 1'b1; ld[LD_YIN] = 1'b1;
                    end
                    CLS_UNARY: begin
                        gr[GR_B] = 1'b1; drv[DRV_ROUT] = 1'b1; ld[LD_ZIN] = 1'b1;
                    end
                    CLS_MULDIV: begin
                        gr[GR_A] = 1'b1; drv[DRV_ROUT] = 1'b1; ld[LD_YIN] = 1'b1;
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        gr[GR_B] = 1'b1; drv[DRV_BAOUT] = 1'b1; ld[LD_YIN] = 1'b1;
                    end
                    CLS_MFHI: begin
                        drv[DRV_HIOUT] = 1'b1; gr[GR_A] = 1'b1; ld[LD_RIN] = 1'b1;
                    end
                    CLS_MFLO: begin
                        drv[DRV_LOOUT] = 1'b1; gr[GR_A] = 1'b1; ld[LD_RIN] = 1'b1;
                    end
                    CLS_ILLEGAL: Illegal = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                case (r_cls)
                    CLS_RTYPE: begin
                        gr[GR_C] = 1'b1; drv[DRV_ROUT] = 1'b1; ld[LD_ZIN] = 1'b1;
                    end
                    CLS_IMM, CLS_LD, CLS_LDI, CLS_ST: begin
                        drv[DRV_COUT] = 1'b1; ld[LD_ZIN] = 1'b1;
                    end
                    CLS_UNARY: begin
                        drv[DRV_ZLOUT] = 1'b1; gr[GR_A] = 1'b1; ld[LD_RIN] = 1'b1;
                    end
                    CLS_MULDIV: begin
                        gr[GR_B] = 1'b1; drv[DRV_ROUT] = 1'b1; ld[LD_ZIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (r_cls)
                    CLS_RTYPE, CLS_IMM, CLS_LDI: begin
                        drv[DRV_ZLOUT] = 1'b1; gr[GR_A] = 1'b1; ld[LD_RIN] = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        drv[DRV_ZLOUT] = 1'b1; ld[LD_MARIN] = 1'b1;
                    end
                    CLS_MULDIV: begin
                        drv[DRV_ZLOUT] = 1'b1; ld[LD_LOIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (r_cls)
                    CLS_LD: begin
                        Read = 1'b1; ld[LD_MDRIN] = 1'b1;
                    end
                    // Store routes the register into MDR, not memory data
                    CLS_ST: begin
                        gr[GR_A] = 1'b1; drv[DRV_ROUT] = 1'b1; ld[LD_MDRIN] = 1'b1;
                    end
                    CLS_MULDIV: begin
                        drv[DRV_ZHOUT] = 1'b1; ld[LD_HIIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (r_cls)
                    CLS_LD: begin
                        drv[DRV_MDROUT] = 1'b1; gr[GR_A] = 1'b1; ld[LD_RIN] = 1'b1;
                    end
                    CLS_ST:  Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
`ifndef CU_MULDIV_EN
        ld[LD_HIIN] = 1'b0;
        ld[LD_LOIN] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Scoreboard bench: the stimulus process runs instructions with random
// operand bits, random Stop noise and random opcodes, pushing one expected
// control word per clock cycle from a step-table reference model. A monitor
// pops and compares one entry on every falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_control_unit;

    localparam int MW = 2;

    // Strobe positions as listed in the port description
    localparam int D_PC = 8, D_ZH = 7, D_ZL = 6, D_MDR = 5, D_HI = 4, D_LO = 3, D_C = 2, D_BA = 1, D_R = 0;
    localparam int L_PC = 8, L_IR = 7, L_MAR = 6, L_MDR = 5, L_Y = 4, L_Z = 3, L_HI = 2, L_LO = 1, L_R = 0;
    localparam int G_A = 2, G_B = 1, G_C = 0;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic        Stop  = 1'b0;
    logic [31:0] IR    = '0;
    logic [8:0]  drv, ld;
    logic [2:0]  gr;
    logic        IncPC, Read, Write, Run, Illegal;
    logic [4:0]  alu_op;

    control_unit #(
        .IR_W     (32),
        .OPC_W    (5),
        .MEM_WAIT (MW)
    ) dut (
        .Clock   (Clock),
        .Clear   (Clear),
        .IR      (IR),
        .Stop    (Stop),
        .drv     (drv),
        .ld      (ld),
        .gr      (gr),
        .IncPC   (IncPC),
        .Read    (Read),
        .Write   (Write),
        .alu_op  (alu_op),
        .Run     (Run),
        .Illegal (Illegal)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [8:0] drv;
        logic [8:0] ld;
        logic [2:0] gr;
        logic       inc;
        logic       rd;
        logic       wr;
        logic       run;
        logic       ill;
    } ctl_t;

    typedef struct {
        ctl_t       c;
        logic       chk_alu;
        logic [4:0] alu;
        logic [4:0] opc;
        int         step;
    } exp_t;

    exp_t sb_q[$];
    exp_t steps[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [8:0] b9(input int i);
        return 9'(1) << i;
    endfunction

    function automatic logic [2:0] g3(input int i);
        return 3'(1) << i;
    endfunction

    function automatic ctl_t mk(input logic [8:0] d, input logic [8:0] l, input logic [2:0] g,
                                input logic inc, input logic rd, input logic wr, input logic ill);
        ctl_t c;
        c.drv = d; c.ld = l; c.gr = g;
        c.inc = inc; c.rd = rd; c.wr = wr; c.run = 1'b1; c.ill = ill;
        return c;
    endfunction

    // Reference model: the fetch steps plus the per-class step list.
    task automatic model_instr(input logic [4:0] opc);
        ctl_t       t[$];
        logic [4:0] alu;
        logic       chk;
        int         o;
        exp_t       e;
        o   = int'(opc);
        chk = 1'b1;
        alu = opc;
        t.push_back(mk(b9(D_PC), b9(L_MAR) | b9(L_Z), 3'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i <= MW; i++)
            t.push_back(mk(b9(D_ZL), b9(L_PC) | b9(L_MDR), 3'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        t.push_back(mk(b9(D_MDR), b9(L_IR), 3'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (o >= 3 && o <= 11) begin
            t.push_back(mk(b9(D_R), b9(L_Y), g3(G_B), 0, 0, 0, 0));
            t.push_back(mk(b9(D_R), b9(L_Z), g3(G_C), 0, 0, 0, 0));
            t.push_back(mk(b9(D_ZL), b9(L_R), g3(G_A), 0, 0, 0, 0));
        end else if (o >= 12 && o <= 14) begin
            alu = (o == 12) ? 5'd3 : (o == 13) ? 5'd5 : 5'd6;
            t.push_back(mk(b9(D_R), b9(L_Y), g3(G_B), 0, 0, 0, 0));
            t.push_back(mk(b9(D_C), b9(L_Z), 3'b0, 0, 0, 0, 0));
            t.push_back(mk(b9(D_ZL), b9(L_R), g3(G_A), 0, 0, 0, 0));
        end else if (o == 17 || o == 18) begin
            t.push_back(mk(b9(D_R), b9(L_Z), g3(G_B), 0, 0, 0, 0));
            t.push_back(mk(b9(D_ZL), b9(L_R), g3(G_A), 0, 0, 0, 0));
`ifdef CU_MULDIV_EN
        end else if (o == 15 || o == 16) begin
            t.push_back(mk(b9(D_R), b9(L_Y), g3(G_A), 0, 0, 0, 0));
            t.push_back(mk(b9(D_R), b9(L_Z), g3(G_B), 0, 0, 0, 0));
            t.push_back(mk(b9(D_ZL), b9(L_LO), 3'b0, 0, 0, 0, 0));
            t.push_back(mk(b9(D_ZH), b9(L_HI), 3'b0, 0, 0, 0, 0));
`endif
        end else if (o <= 2) begin
            alu = 5'd3;
            t.push_back(mk(b9(D_BA), b9(L_Y), g3(G_B), 0, 0, 0, 0));
            t.push_back(mk(b9(D_C), b9(L_Z), 3'b0, 0, 0, 0, 0));
            if (o == 1) begin
                t.push_back(mk(b9(D_ZL), b9(L_R), g3(G_A), 0, 0, 0, 0));
            end else begin
                t.push_back(mk(b9(D_ZL), b9(L_MAR), 3'b0, 0, 0, 0, 0));
                if (o == 0) begin
                    for (int i = 0; i <= MW; i++)
                        t.push_back(mk(9'b0, b9(L_MDR), 3'b0, 0, 1, 0, 0));
                    t.push_back(mk(b9(D_MDR), b9(L_R), g3(G_A), 0, 0, 0, 0));
                end else begin
                    t.push_back(mk(b9(D_R), b9(L_MDR), g3(G_A), 0, 0, 0, 0));
                    t.push_back(mk(9'b0, 9'b0, 3'b0, 0, 0, 1, 0));
                end
            end
        end else if (o == 24 || o == 25) begin
            chk = 1'b0;
            t.push_back(mk((o == 24) ? b9(D_HI) : b9(D_LO), b9(L_R), g3(G_A), 0, 0, 0, 0));
        end else if (o == 26 || o == 27) begin
            chk = 1'b0;
        end else begin
            chk = 1'b0;
            t.push_back(mk(9'b0, 9'b0, 3'b0, 0, 0, 0, 1));
        end
        steps.delete();
        foreach (t[i]) begin
            e.c       = t[i];
            e.chk_alu = (i >= MW + 4) ? chk : 1'b0;
            e.alu     = alu;
            e.opc     = opc;
            e.step    = i;
            steps.push_back(e);
        end
    endtask

    // All-quiet cycle: in RESET alu_op is also expected to read 0
    function automatic void push_quiet(input logic chk_alu, input int tag);
        exp_t e;
        e.c       = '0;
        e.chk_alu = chk_alu;
        e.alu     = 5'd0;
        e.opc     = 5'd0;
        e.step    = tag;
        sb_q.push_back(e);
    endfunction

    // Called at posedge+1; returns at posedge+1 of the first T0 cycle.
    task automatic apply_reset(input int hold);
        Clear = 1'b0;
        for (int i = 0; i < hold; i++) begin
            push_quiet(1'b1, -1);
            @(posedge Clock); #1;
        end
        Clear = 1'b1;
        push_quiet(1'b1, -1);
        @(posedge Clock); #1;
    endtask

    task automatic run_instr(input logic [4:0] opc, input logic stop_end, input int abort_at);
        int n;
        IR = {opc, 27'($urandom)};
        model_instr(opc);
        n = steps.size();
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                apply_reset(2);
                return;
            end
            sb_q.push_back(steps[k]);
            Stop = (k == n - 1) ? stop_end : 1'($urandom_range(0, 1));
            @(posedge Clock); #1;
        end
        Stop = 1'b0;
        if (stop_end || opc == 5'b11011) begin
            repeat (3) begin
                push_quiet(1'b0, -2);
                @(posedge Clock); #1;
            end
            apply_reset(1);
        end
    endtask

    // Monitor: one comparison per cycle, plus alu_op where defined
    initial begin
        exp_t e;
        ctl_t act;
        forever begin
            @(negedge Clock);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = '{drv: drv, ld: ld, gr: gr, inc: IncPC, rd: Read, wr: Write, run: Run, ill: Illegal};
                n_checks++;
                if (act !== e.c) begin
                    n_errors++;
                    $display("FAIL ctl opc=%b step=%0d t=%0t: got drv=%b ld=%b gr=%b inc/rd/wr/run/ill=%b%b%b%b%b, expected drv=%b ld=%b gr=%b inc/rd/wr/run/ill=%b%b%b%b%b",
                             e.opc, e.step, $time, act.drv, act.ld, act.gr, act.inc, act.rd, act.wr, act.run, act.ill,
                             e.c.drv, e.c.ld, e.c.gr, e.c.inc, e.c.rd, e.c.wr, e.c.run, e.c.ill);
                end
                if (e.chk_alu) begin
                    n_checks++;
                    if (alu_op !== e.alu) begin
                        n_errors++;
                        $display("FAIL alu_op opc=%b step=%0d t=%0t: got %b expected %b",
                                 e.opc, e.step, $time, alu_op, e.alu);
                    end
                end
            end
        end
    end

    initial begin
        logic [4:0] dir_ops[14];
        logic [4:0] opc;
        dir_ops = '{5'b00101, 5'b10001, 5'b00000, 5'b00010, 5'b00001, 5'b11000, 5'b11001,
                    5'b11010, 5'b01100, 5'b01101, 5'b01110, 5'b10111, 5'b01111, 5'b10000};
        @(posedge Clock); #1;
        apply_reset(2);
        foreach (dir_ops[i]) run_instr(dir_ops[i], 1'b0, -1);
        run_instr(5'b00011, 1'b0, MW + 4);     // Clear during T4 of add
        run_instr(5'b00011, 1'b0, -1);
        run_instr(5'b01111, 1'b1, -1);         // Stop at the last step of mul
        run_instr(5'b11011, 1'b0, -1);         // halt
        run_instr(5'b11010, 1'b1, -1);         // Stop at the last step of nop
        run_instr(5'b00010, 1'b0, -1);
        for (int i = 0; i < 200; i++) begin
            opc = 5'($urandom_range(0, 31));
            run_instr(opc, ($urandom_range(0, 15) == 0), -1);
        end
        Stop = 1'b0;
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
            @(negedge Clock); #1;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expected cycles left unchecked, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
